// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780-style 4-bit bus receiver.
// Holds opcode classes, DDRAM address map limits, blank fill value and FSM states.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_INIT8,
        ST_NIB_HI,
        ST_NIB_LO,
        ST_CLEAR
    } lcd_state_e;

    // Instruction classes, keyed by the highest set bit of the byte
    localparam logic [7:0] OP_CLEAR = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;
    localparam logic [7:0] OP_ENTRY = 8'h04;
    localparam logic [7:0] OP_DISP  = 8'h08;
    localparam logic [7:0] OP_SHIFT = 8'h10;
    localparam logic [7:0] OP_FSET  = 8'h20;
    localparam logic [7:0] OP_CGRAM = 8'h40;
    localparam logic [7:0] OP_DDRAM = 8'h80;

    // 8-bit mode nibbles
    localparam logic [3:0] NIB_STAY8 = 4'h3;
    localparam logic [3:0] NIB_GO4   = 4'h2;

    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE1_LAST = 7'h27;
    localparam logic [6:0] LINE2_LAST = 7'h67;

    localparam logic [7:0] BLANK       = 8'h20;
    localparam int         DDRAM_DEPTH = 32;

    // Isolate the highest set bit; 0x00 maps to 0x00
    function automatic logic [7:0] top_bit(input logic [7:0] b);
        top_bit = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                top_bit    = '0;
                top_bit[i] = 1'b1;
            end
        end
    endfunction

    // Address counter step with the two-line wrap map
    function automatic logic [6:0] ac_step(input logic [6:0] a,
                                           input logic       inc);
        if (inc) begin
            if (a == LINE1_LAST)      ac_step = LINE2_BASE;
            else if (a == LINE2_LAST) ac_step = LINE1_BASE;
            else                      ac_step = a + 7'd1;
        end else begin
            if (a == LINE1_BASE)      ac_step = LINE2_LAST;
            else if (a == LINE2_BASE) ac_step = LINE1_LAST;
            else                      ac_step = a - 7'd1;
        end
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// lcd_ddram: 32x8 display mirror, one write port, registered read port.
// Ports: i_clk, i_rst (clears read reg only), i_we/i_waddr/i_wdata, i_raddr -> o_rdata.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_we,
    input  logic [4:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic [4:0] i_raddr,
    output logic [7:0] o_rdata
);

    logic [7:0] r_mem [DDRAM_DEPTH];
    logic [7:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Read-before-write: same-cycle write is not visible
    always_ff @(posedge i_clk) begin
        if (i_rst) r_rdata <= '0;
        else       r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lcd_rx.sv
// lcd_rx: decodes en/rs/rw/data strobes of a 4-bit character-LCD bus into bytes,
// tracks controller state (AC, I/D, display bits, modes) and a 2x16 DDRAM mirror.
// Ports: clk, rst (sync, high), en/rs/rw/data bus in, rd_addr -> rd_char mirror read,
// byte_valid/byte_out/byte_rs decoded byte, err drop pulse, busy (clear fill),
// four_bit, disp_on, cursor_on, blink_on, ac.
module lcd_rx
    import lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rs,
    input  logic       rw,
    input  logic [3:0] data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       byte_rs,
    output logic       err,
    output logic       busy,
    output logic       four_bit,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic [6:0] ac
);

    // ---------------- input synchronizer ----------------
    logic [SYNC_STAGES-1:0][6:0] r_sync;
    logic                        r_en_d;
    logic                        w_en, w_rs, w_rw;
    logic [3:0]                  w_nib;
    logic                        w_stb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_en_d <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], {en, rs, rw, data}};
            r_en_d <= w_en;
        end
    end

    assign {w_en, w_rs, w_rw, w_nib} = r_sync[SYNC_STAGES-1];
    // Read strobes are invisible to everything downstream
    assign w_stb = r_en_d & ~w_en & ~w_rw;

    // ---------------- state ----------------
    lcd_state_e r_state, w_state_nxt;
    lcd_state_e r_ret,   w_ret_nxt;
    logic [4:0] r_clr_cnt, w_cnt_nxt;

    logic [3:0] r_hi_nib, w_hi_nib_nxt;
    logic       r_hi_rs,  w_hi_rs_nxt;
    logic [6:0] r_ac,     w_ac_nxt;
    logic       r_id,     w_id_nxt;
    logic       r_s_unused, w_s_nxt;
    logic       r_n_unused, w_n_nxt;
    logic       r_cg,     w_cg_nxt;
    logic       r_four,   w_four_nxt;
    logic       r_disp,   w_disp_nxt;
    logic       r_cur,    w_cur_nxt;
    logic       r_blink,  w_blink_nxt;
    logic       r_bv,     w_bv_nxt;
    logic [7:0] r_bout,   w_bout_nxt;
    logic       r_brs,    w_brs_nxt;
    logic       r_err,    w_err_nxt;

    logic       w_we;
    logic [4:0] w_waddr;
    logic [7:0] w_wdata;

    logic [7:0] w_byte;
    logic [7:0] w_op;
    logic       w_pair_ok;
    logic       w_go4;

    assign w_byte    = {r_hi_nib, w_nib};
    assign w_op      = top_bit(w_byte);
    assign w_pair_ok = (w_rs == r_hi_rs);
    assign w_go4     = w_stb && !w_rs && (w_nib == NIB_GO4);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_ret     <= ST_INIT8;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ret     <= w_ret_nxt;
            r_clr_cnt <= w_cnt_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_cnt_nxt   = r_clr_cnt;
        unique case (r_state)
            ST_INIT8: begin
                if (w_go4) w_state_nxt = ST_NIB_HI;
            end
            ST_NIB_HI: begin
                if (w_stb) w_state_nxt = ST_NIB_LO;
            end
            ST_NIB_LO: begin
                if (w_stb) begin
                    w_state_nxt = ST_NIB_HI;
                    if (w_pair_ok && !w_rs) begin
                        if (w_op == OP_CLEAR) begin
                            w_state_nxt = ST_CLEAR;
                            w_ret_nxt   = ST_NIB_HI;
                            w_cnt_nxt   = '0;
                        end else if (w_op == OP_FSET && w_byte[4]) begin
                            w_state_nxt = ST_INIT8;
                        end
                    end
                end
            end
            ST_CLEAR: begin
                w_cnt_nxt = r_clr_cnt + 5'd1;
                if (r_clr_cnt == 5'd31) w_state_nxt = r_ret;
            end
            default: ;
        endcase
    end

    // ---------------- FSM: outputs / datapath next ----------------
    always_comb begin
        w_hi_nib_nxt = r_hi_nib;
        w_hi_rs_nxt  = r_hi_rs;
        w_ac_nxt     = r_ac;
        w_id_nxt     = r_id;
        w_s_nxt      = r_s_unused;
        w_n_nxt      = r_n_unused;
        w_cg_nxt     = r_cg;
        w_four_nxt   = r_four;
        w_disp_nxt   = r_disp;
        w_cur_nxt    = r_cur;
        w_blink_nxt  = r_blink;
        w_bv_nxt     = 1'b0;
        w_bout_nxt   = r_bout;
        w_brs_nxt    = r_brs;
        w_err_nxt    = 1'b0;
        w_we         = 1'b0;
        w_waddr      = r_clr_cnt;
        w_wdata      = BLANK;
        unique case (r_state)
            ST_INIT8: begin
                if (w_go4) w_four_nxt = 1'b1;
            end
            ST_NIB_HI: begin
                if (w_stb) begin
                    w_hi_nib_nxt = w_nib;
                    w_hi_rs_nxt  = w_rs;
                end
            end
            ST_NIB_LO: begin
                if (w_stb && !w_pair_ok) begin
                    w_err_nxt = 1'b1;
                end else if (w_stb) begin
                    w_bv_nxt   = 1'b1;
                    w_bout_nxt = w_byte;
                    w_brs_nxt  = w_rs;
                    if (w_rs) begin
                        // Only 0x00-0x0F / 0x40-0x4F have a mirror slot
                        w_we     = !r_cg && (r_ac[5:4] == 2'b00);
                        w_waddr  = {r_ac[6], r_ac[3:0]};
                        w_wdata  = w_byte;
                        w_ac_nxt = ac_step(r_ac, r_id);
                    end else begin
                        unique case (w_op)
                            OP_CLEAR: begin
                                w_ac_nxt = '0;
                                w_id_nxt = 1'b1;
                                w_cg_nxt = 1'b0;
                            end
                            OP_HOME: begin
                                w_ac_nxt = '0;
                                w_cg_nxt = 1'b0;
                            end
                            OP_ENTRY: begin
                                w_id_nxt = w_byte[1];
                                w_s_nxt  = w_byte[0];
                            end
                            OP_DISP: begin
                                w_disp_nxt  = w_byte[2];
                                w_cur_nxt   = w_byte[1];
                                w_blink_nxt = w_byte[0];
                            end
                            OP_SHIFT: ;
                            OP_FSET: begin
                                w_n_nxt = w_byte[3];
                                if (w_byte[4]) w_four_nxt = 1'b0;
                            end
                            OP_CGRAM: begin
                                w_cg_nxt = 1'b1;
                            end
                            OP_DDRAM: begin
                                w_ac_nxt = w_byte[6:0];
                                w_cg_nxt = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_CLEAR: begin
                w_we = 1'b1;
                if (w_stb) w_err_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi_nib   <= '0;
            r_hi_rs    <= 1'b0;
            r_ac       <= '0;
            r_id       <= 1'b1;
            r_s_unused <= 1'b0;
            r_n_unused <= 1'b0;
            r_cg       <= 1'b0;
            r_four     <= 1'b0;
            r_disp     <= 1'b0;
            r_cur      <= 1'b0;
            r_blink    <= 1'b0;
            r_bv       <= 1'b0;
            r_bout     <= '0;
            r_brs      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_hi_nib   <= w_hi_nib_nxt;
            r_hi_rs    <= w_hi_rs_nxt;
            r_ac       <= w_ac_nxt;
            r_id       <= w_id_nxt;
            r_s_unused <= w_s_nxt;
            r_n_unused <= w_n_nxt;
            r_cg       <= w_cg_nxt;
            r_four     <= w_four_nxt;
            r_disp     <= w_disp_nxt;
            r_cur      <= w_cur_nxt;
            r_blink    <= w_blink_nxt;
            r_bv       <= w_bv_nxt;
            r_bout     <= w_bout_nxt;
            r_brs      <= w_brs_nxt;
            r_err      <= w_err_nxt;
        end
    end

    lcd_ddram u_ddram (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (w_we && !rst),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (rd_addr),
        .o_rdata (rd_char)
    );

    assign byte_valid = r_bv;
    assign byte_out   = r_bout;
    assign byte_rs    = r_brs;
    assign err        = r_err;
    assign busy       = (r_state == ST_CLEAR);
    assign four_bit   = r_four;
    assign disp_on    = r_disp;
    assign cursor_on  = r_cur;
    assign blink_on   = r_blink;
    assign ac         = r_ac;

endmodule

// File: tb/tb_lcd_rx.sv
// tb_lcd_rx: self-checking bench for lcd_rx; table vectors, hand sequences,
// and random traffic checked against a line/position model of the controller.
module tb_lcd_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, rs = 1'b0, rw = 1'b0;
    logic [3:0] data = '0;
    logic [4:0] rd_addr = '0;
    logic [7:0] rd_char, byte_out;
    logic       byte_valid, byte_rs, err, busy;
    logic       four_bit, disp_on, cursor_on, blink_on;
    logic [6:0] ac;

    lcd_rx #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .en(en), .rs(rs), .rw(rw), .data(data),
        .rd_addr(rd_addr), .rd_char(rd_char), .byte_valid(byte_valid),
        .byte_out(byte_out), .byte_rs(byte_rs), .err(err), .busy(busy),
        .four_bit(four_bit), .disp_on(disp_on), .cursor_on(cursor_on),
        .blink_on(blink_on), .ac(ac)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int bv_cnt = 0, err_cnt = 0;
    int busy_len = 0, busy_last = 0;

    always @(negedge clk) begin
        if (byte_valid) bv_cnt++;
        if (err) err_cnt++;
        if (busy && !rst) busy_len++;
        else if (!busy && busy_len != 0) begin
            busy_last = busy_len;
            busy_len  = 0;
        end
    end

    // ---------- reference model ----------
    logic [7:0] m_mem [32];
    int         m_ac;
    bit         m_id, m_cg, m_four, m_disp, m_cur, m_blink;

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        m_ac = 0; m_id = 1; m_cg = 0; m_four = 0;
        m_disp = 0; m_cur = 0; m_blink = 0;
    endfunction

    function automatic void m_step();
        int line, pos;
        line = m_ac / 64;
        pos  = m_ac % 64;
        if (m_id) begin
            pos++;
            if (pos > 39) begin pos = 0; line = 1 - line; end
        end else begin
            if (pos == 0) begin pos = 39; line = 1 - line; end
            else pos--;
        end
        m_ac = line * 64 + pos;
    endfunction

    function automatic void m_byte(input bit r, input logic [7:0] b);
        if (r) begin
            if (!m_cg && (m_ac % 64) < 16)
                m_mem[(m_ac / 64) * 16 + (m_ac % 64)] = b;
            m_step();
        end else if (b >= 128) begin
            m_ac = b - 128; m_cg = 0;
        end else if (b >= 64) begin
            m_cg = 1;
        end else if (b >= 32) begin
            if (b[4]) m_four = 0;
        end else if (b >= 16) begin
        end else if (b >= 8) begin
            m_disp = b[2]; m_cur = b[1]; m_blink = b[0];
        end else if (b >= 4) begin
            m_id = b[1];
        end else if (b >= 2) begin
            m_ac = 0; m_cg = 0;
        end else if (b == 1) begin
            m_ac = 0; m_id = 1; m_cg = 0;
            for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        end
    endfunction

    // ---------- helpers ----------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_nib(input logic r, input logic w, input logic [3:0] n);
        rs = r; rw = w; data = n;
        tick();
        en = 1'b1;
        repeat (3) tick();
        en = 1'b0;
        repeat (6) tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin tick(); n++; end
        chk("busy_timeout", 32'(busy), 0);
        tick();
    endtask

    task automatic do_byte(input logic r, input logic [7:0] b);
        int bv0, e0;
        bv0 = bv_cnt; e0 = err_cnt;
        send_nib(r, 1'b0, b[7:4]);
        send_nib(r, 1'b0, b[3:0]);
        m_byte(r, b);
        chk("bv_pulse", 32'(bv_cnt - bv0), 1);
        chk("no_err", 32'(err_cnt - e0), 0);
        chk("byte_out", {23'd0, byte_rs, byte_out}, {23'd0, r, b});
        if (!r && b == 8'h01) wait_idle();
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_ac"}, 32'(ac), 32'(m_ac));
        chk({tag, "_flags"}, {28'd0, four_bit, disp_on, cursor_on, blink_on},
            {28'd0, m_four, m_disp, m_cur, m_blink});
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            tick();
            chk($sformatf("%s[%0d]", tag, i), 32'(rd_char), 32'(m_mem[i]));
        end
    endtask

    task automatic do_init();
        logic [3:0] seq [5];
        seq = '{4'h3, 4'h3, 4'h3, 4'h0, 4'h2};
        foreach (seq[i]) send_nib(1'b0, 1'b0, seq[i]);
        m_four = 1;
        chk("init_four", 32'(four_bit), 1);
        do_byte(1'b0, 8'h28);
        do_byte(1'b0, 8'h0C);
        do_byte(1'b0, 8'h01);
        chk("init_busy_len", 32'(busy_last), 32);
        do_byte(1'b0, 8'h06);
    endtask

    typedef struct {
        logic       rs;
        logic [7:0] b;
        logic [6:0] ac;
        logic [2:0] dcb;
    } vec_t;

    vec_t tbl [27];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int bv0, e0, op;
        logic [7:0] b;
        logic       r;

        tbl = '{
            '{1'b0, 8'h80, 7'h00, 3'b100}, '{1'b1, 8'h33, 7'h01, 3'b100},
            '{1'b1, 8'h41, 7'h02, 3'b100}, '{1'b0, 8'hC0, 7'h40, 3'b100},
            '{1'b1, 8'h35, 7'h41, 3'b100}, '{1'b0, 8'hA7, 7'h27, 3'b100},
            '{1'b1, 8'h58, 7'h40, 3'b100}, '{1'b1, 8'h46, 7'h41, 3'b100},
            '{1'b0, 8'h0F, 7'h41, 3'b111}, '{1'b0, 8'h04, 7'h41, 3'b111},
            '{1'b1, 8'h4A, 7'h40, 3'b111}, '{1'b1, 8'h4B, 7'h27, 3'b111},
            '{1'b1, 8'h4C, 7'h26, 3'b111}, '{1'b0, 8'h06, 7'h26, 3'b111},
            '{1'b0, 8'h80, 7'h00, 3'b111}, '{1'b0, 8'h04, 7'h00, 3'b111},
            '{1'b1, 8'h50, 7'h67, 3'b111}, '{1'b1, 8'h51, 7'h66, 3'b111},
            '{1'b0, 8'h06, 7'h66, 3'b111}, '{1'b0, 8'hE7, 7'h67, 3'b111},
            '{1'b1, 8'h52, 7'h00, 3'b111}, '{1'b0, 8'h48, 7'h00, 3'b111},
            '{1'b1, 8'h53, 7'h01, 3'b111}, '{1'b0, 8'h02, 7'h00, 3'b111},
            '{1'b1, 8'h54, 7'h01, 3'b111}, '{1'b0, 8'h18, 7'h01, 3'b111},
            '{1'b0, 8'h08, 7'h01, 3'b000}
        };

        // Reset state
        m_reset();
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 1);
        chk("rst_outs", {byte_valid, err, byte_rs, byte_out, rd_char},
            32'd0);
        check_flags("rst");
        rst = 1'b0;
        wait_idle();
        chk("por_busy_len", 32'(busy_last), 32);

        // Init sequence
        do_init();
        check_flags("init");
        check_mem("init_mem");
        chk("init_errs", 32'(err_cnt), 0);

        // Table vectors
        foreach (tbl[i]) begin
            do_byte(tbl[i].rs, tbl[i].b);
            chk($sformatf("tbl%0d_ac", i), 32'(ac), 32'(tbl[i].ac));
            chk($sformatf("tbl%0d_dcb", i),
                {29'd0, disp_on, cursor_on, blink_on}, {29'd0, tbl[i].dcb});
        end
        check_mem("tbl_mem");

        // rw=1 strobe between nibbles is ignored
        do_byte(1'b0, 8'h80);
        bv0 = bv_cnt; e0 = err_cnt;
        send_nib(1'b1, 1'b0, 4'h6);
        send_nib(1'b0, 1'b1, 4'hF);
        send_nib(1'b1, 1'b0, 4'h1);
        m_byte(1'b1, 8'h61);
        chk("rw_bv", 32'(bv_cnt - bv0), 1);
        chk("rw_err", 32'(err_cnt - e0), 0);
        chk("rw_byte", 32'(byte_out), 32'h61);

        // rs mismatch drops the byte
        bv0 = bv_cnt; e0 = err_cnt;
        send_nib(1'b1, 1'b0, 4'h7);
        send_nib(1'b0, 1'b0, 4'h7);
        chk("mis_err", 32'(err_cnt - e0), 1);
        chk("mis_bv", 32'(bv_cnt - bv0), 0);
        check_flags("mis");
        do_byte(1'b1, 8'h62);
        check_mem("proto_mem");

        // Strobe during Clear
        e0 = err_cnt;
        send_nib(1'b0, 1'b0, 4'h0);
        send_nib(1'b0, 1'b0, 4'h1);
        m_byte(1'b0, 8'h01);
        chk("clr_busy", 32'(busy), 1);
        send_nib(1'b0, 1'b0, 4'h8);
        chk("clr_strobe_err", 32'(err_cnt - e0), 1);
        wait_idle();
        chk("clr_busy_len", 32'(busy_last), 32);
        check_mem("clr_mem");
        do_byte(1'b0, 8'hC3);
        check_flags("after_clr");

        // Randomized traffic
        for (int k = 0; k < 150; k++) begin
            op = $urandom_range(0, 9);
            b  = 8'($urandom);
            bv0 = bv_cnt; e0 = err_cnt;
            if (op <= 3) begin
                do_byte(1'b1, b);
            end else if (op == 4) begin
                do_byte(1'b0, 8'h80 | 8'(($urandom % 2) * 64 + $urandom % 40));
            end else if (op == 5) begin
                do_byte(1'b0, 8'h04 | (b & 8'h03));
            end else if (op == 6) begin
                do_byte(1'b0, 8'h08 | (b & 8'h07));
            end else if (op == 7) begin
                case ($urandom % 3)
                    0: do_byte(1'b0, 8'h02);
                    1: do_byte(1'b0, 8'h40 | (b & 8'h3F));
                    default: do_byte(1'b0, 8'h10 | (b & 8'h0F));
                endcase
            end else if (op == 8) begin
                r = 1'($urandom);
                send_nib(r, 1'b0, b[7:4]);
                send_nib(!r, 1'b0, b[3:0]);
                chk("rnd_mis_err", 32'(err_cnt - e0), 1);
                chk("rnd_mis_bv", 32'(bv_cnt - bv0), 0);
            end else begin
                send_nib(1'b1, 1'b0, b[7:4]);
                send_nib(1'($urandom), 1'b1, 4'($urandom));
                send_nib(1'b1, 1'b0, b[3:0]);
                m_byte(1'b1, b);
                chk("rnd_rw_bv", 32'(bv_cnt - bv0), 1);
                chk("rnd_rw_err", 32'(err_cnt - e0), 0);
            end
            check_flags("rnd");
        end
        check_mem("rnd_mem");

        // Reset mid-byte
        send_nib(1'b1, 1'b0, 4'h5);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        m_reset();
        chk("mid_four", 32'(four_bit), 0);
        wait_idle();
        chk("mid_busy_len", 32'(busy_last), 32);
        check_flags("mid");
        send_nib(1'b0, 1'b0, 4'h2);
        m_four = 1;
        chk("mid_four_again", 32'(four_bit), 1);
        do_byte(1'b0, 8'h80);
        do_byte(1'b1, 8'h5A);
        check_flags("mid_after");
        check_mem("mid_mem");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_rx.md
# lcd_rx

Receiving end of the HD44780-style 4-bit character-LCD bus. The block sits on the `en/rs/rw/data[3:0]` pins that the LCD driver produces, and decodes the strobes into instructions and character writes. It maintains a 2×16 display-RAM mirror plus controller state, so the on-screen contents can be checked in simulation, forwarded to another sink, or read back by the core. It is write-only, like the bus it listens to.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on `en/rs/rw/data`; minimum 2.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: LCD enable strobe. Data is latched on its falling edge.
- `rs`, in, 1: register select (0 = instruction, 1 = data).
- `rw`, in, 1: read/write (1 = read; ignored).
- `data`, in, 4: bus nibble.
- `rd_addr`, in, 5: mirror read index. 0–15 is line 1, 16–31 is line 2.
- `rd_char`, out, 8: registered read data.
- `byte_valid`, out, 1: one-cycle pulse when a complete byte is decoded.
- `byte_out`, out, 8: the decoded byte, held until the next `byte_valid`.
- `byte_rs`, out, 1: the `rs` value of `byte_out`.
- `err`, out, 1: one-cycle pulse when a strobe or byte is dropped.
- `busy`, out, 1: high while a clear is in progress.
- `four_bit`, out, 1: high when 4-bit mode is active.
- `disp_on`, `cursor_on`, `blink_on`, out, 1 each: Display Control bits.
- `ac`, out, 7: address counter.

## Operation

**Strobe capture**
- All inputs pass through `SYNC_STAGES` flops.
- A strobe is a falling edge on synchronized `en`. The synchronized `rs/rw/data` are sampled in the same cycle.
- Strobes with `rw=1` are ignored: no state change and no `err`. Idle strobes are legal.

**State machine**
- States: INIT8, NIB_HI, NIB_LO, CLEAR.
- INIT8 (8-bit mode, each strobe is one instruction):
  - `rs=0`, nibble 0x3: stay in INIT8.
  - `rs=0`, nibble 0x2: set `four_bit=1`, go to NIB_HI.
  - Any other nibble, or `rs=1`: ignored, no `err`.
- NIB_HI: latch the high nibble and `rs`, go to NIB_LO.
- NIB_LO: assemble `{hi, lo}` and pulse `byte_valid`.
  - If `rs` differs from the high-nibble `rs`: pulse `err`, drop the byte, go to NIB_HI.
- CLEAR: writes 0x20 to one mirror location per cycle for 32 cycles, then returns to the state it came from.
  - Any strobe arriving in CLEAR is dropped and pulses `err`.

**Instruction decode** (`rs=0`, by highest set bit)
- 0x01, Clear: `ac=0`, I/D=1, enter CLEAR.
- 0x02–0x03, Home: `ac=0`.
- 0x04–0x07, Entry Mode: I/D = bit1, S = bit0. S is stored but has no effect.
- 0x08–0x0F, Display Control: `disp_on`, `cursor_on`, `blink_on` = bits 2, 1, 0.
- 0x10–0x1F, Shift: ignored.
- 0x20–0x3F, Function Set: if DL (bit4) = 1, clear `four_bit` and go to INIT8. The N bit is stored.
- 0x40–0x7F, Set CGRAM: set `cg_mode`. While `cg_mode` is set, data writes are discarded but the AC still steps.
- 0x80–0xFF, Set DDRAM: `ac = byte[6:0]`, clear `cg_mode`.
- Clear and Home also clear `cg_mode`.

**Data write** (`rs=1`)
- Mirror index: `{ac[6], ac[3:0]}`, valid only for AC 0x00–0x0F and 0x40–0x4F. Writes to any other address are discarded.
- After every data write, AC steps by +1 (I/D=1) or −1 (I/D=0), whether or not the write landed.
- Increment wraps 0x27→0x40 and 0x67→0x00.
- Decrement wraps 0x00→0x67 and 0x40→0x27.

## Timing

**Reset values**
- State CLEAR, then INIT8 after the fill.
- `busy=1` for 32 cycles after `rst` deasserts.
- `four_bit=0`, `disp_on=0`, `cursor_on=0`, `blink_on=0`.
- `ac=0`, I/D=1, S=0, `cg_mode=0`.
- `byte_valid=0`, `err=0`, `byte_out=0x00`, `byte_rs=0`, `rd_char=0x00`.
- Mirror filled with 0x20.

**Latency**
- Input `en` falls at cycle N → strobe detected at N+`SYNC_STAGES`+1.
- `byte_valid`, the mirror write and the AC update are all registered one cycle after detection of the low-nibble strobe.

**Read port**
- `rd_addr` sampled at cycle K → `rd_char` valid at K+1.
- A read in the same cycle as a write to that location returns the old data.

**Boundary cases**
- `rst` mid-byte discards the half byte. Reset overrides everything.
- A Clear already in progress blocks any new instruction: the strobe is dropped with `err`.

## Structure

- **Package `lcd_pkg`:**
  - Opcode match constants.
  - Line base addresses 0x00/0x40 and wrap limits 0x27/0x67.
  - Blank character 0x20.
  - FSM state enum.
- **Sub-module `lcd_ddram`:** 32×8 storage with one write port and a registered read port, used for both data writes and the CLEAR fill.

## Test plan

1. **Init sequence.** Send nibbles 3, 3, 3, 0, 2 (`rs=0`), then bytes 0x28, 0x0C, 0x01, 0x06 → `four_bit=1`, `disp_on=1`, `cursor_on=0`, `busy` high for exactly 32 cycles, all 32 reads return 0x20, `ac=0`, no `err`.
2. **Line-1 writes.** After init, send 0x80, then data 0x33, 0x41 → index 0 = 0x33, index 1 = 0x41, `ac=0x02`, two data `byte_valid` pulses with `byte_rs=1`.
3. **Line 2 and wrap.** Send 0xC0, data 0x35 → index 16 = 0x35, `ac=0x41`. Then send 0xA7, data 0x58 → discarded, `ac=0x40`. Next data 0x46 lands at index 16.
4. **Protocol errors.** Insert `rw=1` strobes between high and low nibbles → byte decoded correctly, no `err`. Send high nibble with `rs=1` and low nibble with `rs=0` → one `err` pulse, no write. The next pair decodes normally.
5. **Strobe during Clear.** Send 0x01 and strobe 5 cycles later → `err` pulse, strobe ignored, fill completes to 0x20.
6. **Reset mid-byte.** After a lone high nibble, pulse `rst` → `four_bit=0`, `busy` for 32 cycles. A subsequent nibble 0x2 re-enters 4-bit mode.
